// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_pkg
// Purpose  : Command codes and target state type shared by the SPI SRAM pair.
// Revision : 1.0
// ============================================================================
package spi_sram_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    ADDR     = 3'd2,
    DATA_IN  = 3'd3,
    DATA_OUT = 3'd4,
    IGNORE   = 3'd5
  } spi_tgt_state_t;

  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd == SPI_CMD_READ) || (cmd == SPI_CMD_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_responder_if
// Purpose  : SPI bus plus target status lines between initiator and responder.
// Revision : 1.0
// ============================================================================
interface spi_sram_responder_if;

  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic busy;
  logic err_cmd;

  modport master (output sclk, cs, mosi, input miso, miso_oe, busy, err_cmd);
  modport slave  (input sclk, cs, mosi, output miso, miso_oe, busy, err_cmd);

endinterface
`default_nettype wire

// File: rtl/spi_sram_mem.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_mem
// Purpose  : Byte array with one synchronous write port and a combinational read.
// Revision : 1.0
// ============================================================================
module spi_sram_mem #(
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [7:0]        wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_responder
// Purpose  : SPI mode-0 target emulating a 23LC-style serial SRAM (READ/WRITE).
// Revision : 1.0
// ============================================================================
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter bit SEQ_EN = 1'b1
) (
  input wire logic             clk,
  input wire logic             rst,
  spi_sram_responder_if.slave  spi
);

  spi_tgt_state_t    r_state, w_next_state;
  logic              r_sclk_q;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_cmd_sh;
  logic [ADDR_W-2:0] r_addr_sh;
  logic [6:0]        r_rx_sh;
  logic [7:0]        r_tx_sh;
  logic [ADDR_W-1:0] r_addr;
  logic              r_armed;
  logic              r_err_cmd;

  logic              w_rise, w_fall, w_last;
  logic [7:0]        w_cmd_byte, w_wdata, w_rd_data;
  logic [ADDR_W-1:0] w_addr_full, w_addr_inc, w_rd_addr;
  logic              w_we;

  assign w_rise      = spi.sclk & ~r_sclk_q;
  assign w_fall      = ~spi.sclk & r_sclk_q;
  assign w_last      = (r_bit_cnt == 4'd0);
  assign w_cmd_byte  = {r_cmd_sh[6:0], spi.mosi};
  assign w_wdata     = {r_rx_sh, spi.mosi};
  assign w_addr_full = {r_addr_sh, spi.mosi};
  assign w_addr_inc  = r_addr + 1'b1;
  assign w_rd_addr   = (r_state == ADDR) ? w_addr_full : w_addr_inc;
  assign w_we        = !spi.cs && (r_state == DATA_IN) && w_rise && w_last;

  spi_sram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_addr),
    .wdata (w_wdata),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (spi.cs) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:     w_next_state = CMD;
        CMD:      if (w_rise && w_last) w_next_state = cmd_valid(w_cmd_byte) ? ADDR : IGNORE;
        ADDR:     if (w_rise && w_last) w_next_state = (r_cmd_sh == SPI_CMD_READ) ? DATA_OUT : DATA_IN;
        DATA_IN:  if (w_rise && w_last && !SEQ_EN) w_next_state = IGNORE;
        DATA_OUT: if (w_fall && r_armed && w_last && !SEQ_EN) w_next_state = IGNORE;
        default:  w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    spi.miso_oe = (r_state == DATA_OUT) && !spi.cs;
    spi.miso    = spi.miso_oe & r_tx_sh[7];
    spi.busy    = (r_state != IDLE);
    spi.err_cmd = r_err_cmd;
  end

  // The fall that closes the last address clock arrives after DATA_OUT is entered;
  // r_armed skips it so bit 7 stays on miso until the first data rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_q  <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_cmd_sh  <= '0;
      r_addr_sh <= '0;
      r_rx_sh   <= '0;
      r_tx_sh   <= '0;
      r_addr    <= '0;
      r_armed   <= 1'b0;
      r_err_cmd <= 1'b0;
    end else begin
      r_sclk_q  <= spi.sclk;
      r_err_cmd <= 1'b0;
      if (!spi.cs) begin
        case (r_state)
          IDLE: r_bit_cnt <= 4'd7;
          CMD: if (w_rise) begin
            r_cmd_sh <= w_cmd_byte;
            if (w_last) begin
              r_bit_cnt <= 4'd15;
              r_err_cmd <= !cmd_valid(w_cmd_byte);
            end else begin
              r_bit_cnt <= r_bit_cnt - 4'd1;
            end
          end
          ADDR: if (w_rise) begin
            r_addr_sh <= w_addr_full[ADDR_W-2:0];
            if (w_last) begin
              r_addr    <= w_addr_full;
              r_bit_cnt <= 4'd7;
              r_tx_sh   <= w_rd_data;
              r_armed   <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt - 4'd1;
            end
          end
          DATA_IN: if (w_rise) begin
            r_rx_sh <= w_wdata[6:0];
            if (w_last) begin
              r_bit_cnt <= 4'd7;
              r_addr    <= w_addr_inc;
            end else begin
              r_bit_cnt <= r_bit_cnt - 4'd1;
            end
          end
          DATA_OUT: begin
            if (w_rise) r_armed <= 1'b1;
            if (w_fall && r_armed) begin
              if (w_last) begin
                r_bit_cnt <= 4'd7;
                r_addr    <= w_addr_inc;
                r_tx_sh   <= w_rd_data;
              end else begin
                r_bit_cnt <= r_bit_cnt - 4'd1;
                r_tx_sh   <= {r_tx_sh[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sram_responder
// Purpose  : Directed and random SPI frames against a byte-array memory model.
// Revision : 1.0
// ============================================================================
module tb_spi_sram_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_sram_responder_if bus();

  spi_sram_responder #(.ADDR_W(8), .SEQ_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .spi (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] wq [$];
  logic [7:0] rq [$];
  int err_pulses = 0;
  int oe_seen    = 0;

  always @(negedge clk) begin
    if (bus.err_cmd === 1'b1) err_pulses++;
    if (bus.miso_oe === 1'b1) oe_seen++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int div,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      bus.sclk = 1'b0;
      bus.mosi = tx[i];
      repeat (div - 1) @(negedge clk);
      @(negedge clk);
      rx[i]    = bus.miso;
      bus.sclk = 1'b1;
      repeat (div - 1) @(negedge clk);
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    bus.cs   = 1'b0;
    bus.sclk = 1'b0;
    oe_seen  = 0;
  endtask

  task automatic frame_end(input string tag);
    @(negedge clk);
    bus.sclk = 1'b0;
    @(negedge clk);
    bus.cs = 1'b1;
    @(negedge clk);
    check({tag, "_busy_idle"}, 8'(bus.busy), 8'd0);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [15:0] addr, input int div);
    logic [7:0] rx;
    spi_bits(cmd, 8, div, rx);
    spi_bits(addr[15:8], 8, div, rx);
    spi_bits(addr[7:0], 8, div, rx);
  endtask

  task automatic write_frame(input logic [15:0] addr, input int div);
    logic [7:0] rx;
    frame_start();
    send_header(8'h02, addr, div);
    check("wr_busy", 8'(bus.busy), 8'd1);
    foreach (wq[k]) begin
      spi_bits(wq[k], 8, div, rx);
      ref_mem[(int'(addr) + k) % 256] = wq[k];
    end
    frame_end("wr");
    check("wr_no_oe", 8'(oe_seen), 8'd0);
  endtask

  task automatic read_frame(input logic [15:0] addr, input int len, input int div);
    logic [7:0] rx;
    rq.delete();
    frame_start();
    send_header(8'h03, addr, div);
    for (int k = 0; k < len; k++) begin
      spi_bits(8'hFF, 8, div, rx);
      rq.push_back(rx);
      check("rd_data", rx, ref_mem[(int'(addr) + k) % 256]);
      check("rd_oe", 8'(bus.miso_oe), 8'd1);
    end
    frame_end("rd");
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] snap;
    rst = 1'b1; bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_miso", 8'(bus.miso), 8'd0);
    check("rst_oe", 8'(bus.miso_oe), 8'd0);
    check("rst_err", 8'(bus.err_cmd), 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // initialise the whole array so the model is fully known
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back(8'($urandom));
    write_frame(16'h0000, 1);

    // basic write then read
    wq.delete(); wq.push_back(8'hA5);
    write_frame(16'h0012, 1);
    read_frame(16'h0012, 1, 2);
    check("t1_a5", rq[0], 8'hA5);

    // address aliasing
    wq.delete(); wq.push_back(8'h11);
    write_frame(16'h0000, 2);
    wq.delete(); wq.push_back(8'h22);
    write_frame(16'h0100, 1);
    read_frame(16'h0000, 1, 1);
    check("t2_alias", rq[0], 8'h22);

    // sequential write and read across the wrap
    wq.delete(); wq.push_back(8'h33); wq.push_back(8'h44);
    write_frame(16'h00FF, 1);
    read_frame(16'h00FF, 2, 1);
    check("t3_wrap0", rq[0], 8'h33);
    check("t3_wrap1", rq[1], 8'h44);

    // illegal command
    frame_start();
    err_pulses = 0;
    spi_bits(8'h05, 8, 1, rx);
    spi_bits(8'h00, 8, 1, rx);
    spi_bits(8'h12, 8, 1, rx);
    check("t4_busy", 8'(bus.busy), 8'd1);
    check("t4_err_pulses", 8'(err_pulses), 8'd1);
    check("t4_no_oe", 8'(oe_seen), 8'd0);
    frame_end("t4");
    read_frame(16'h0012, 1, 1);

    // write aborted after 5 data bits
    frame_start();
    send_header(8'h02, 16'h0040, 1);
    spi_bits(~ref_mem[8'h40], 5, 1, rx);
    @(negedge clk);
    bus.cs = 1'b1;
    @(negedge clk);
    check("t5_busy", 8'(bus.busy), 8'd0);
    read_frame(16'h0040, 1, 1);

    // 8th rise coincides with cs release: the byte is dropped
    snap = ref_mem[8'h41];
    frame_start();
    send_header(8'h02, 16'h0041, 1);
    spi_bits(~snap, 7, 1, rx);
    @(negedge clk);
    bus.sclk = 1'b0; bus.mosi = ~snap[0];
    @(negedge clk);
    bus.sclk = 1'b1; bus.cs = 1'b1;
    @(negedge clk);
    check("t5b_busy", 8'(bus.busy), 8'd0);
    bus.sclk = 1'b0;
    read_frame(16'h0041, 1, 1);
    check("t5b_kept", rq[0], snap);

    // reset in the middle of a read data phase
    frame_start();
    send_header(8'h03, 16'h0012, 1);
    spi_bits(8'hFF, 3, 1, rx);
    check("t6_oe_before", 8'(bus.miso_oe), 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", 8'(bus.busy), 8'd0);
    check("t6_miso", 8'(bus.miso), 8'd0);
    check("t6_oe", 8'(bus.miso_oe), 8'd0);
    rst = 1'b0; bus.cs = 1'b1; bus.sclk = 1'b0;
    @(negedge clk);
    read_frame(16'h0012, 1, 1);
    check("t6_after", rq[0], 8'hA5);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      int len;
      int div;
      a   = 16'($urandom);
      len = $urandom_range(1, 5);
      div = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
        write_frame(a, div);
      end else begin
        read_frame(a, len, div);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
